// File: rtl/hls_mul_pkg.sv
// Shared constants and elaboration helpers for the hls_mul_pipe multiplier.
package hls_mul_pkg;

    localparam int NUM_STAGE_MIN = 2;
    localparam int NUM_STAGE_MAX = 16;
    localparam int RND_MAX_W     = 256;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Half-up rounding bias: a single 1 in the bit just below the kept LSB.
    function automatic logic [RND_MAX_W-1:0] round_const(input int shift);
        logic [RND_MAX_W-1:0] bias;
        bias = '0;
        if (shift > 0) begin
            bias[shift-1] = 1'b1;
        end
        return bias;
    endfunction

endpackage

// File: rtl/hls_mul_round_sat.sv
// Final-stage post-processing: half-up rounding, arithmetic shift and narrowing.
// With HLS_MUL_PIPE_SAT_EN defined, out-of-range results clamp instead of wrapping.
module hls_mul_round_sat
    import hls_mul_pkg::*;
#(
    parameter int PROD_WIDTH = 63,
    parameter int DOUT_WIDTH = 58,
    parameter int SHIFT      = 0,
    parameter bit SIGNED_OUT = 1'b1
) (
    input  logic [PROD_WIDTH-1:0] prod,
    output logic [DOUT_WIDTH-1:0] result
);

    // One guard bit absorbs the rounding carry, a second keeps the sign clear of both widths.
    localparam int BASE_W = (PROD_WIDTH + 1 > DOUT_WIDTH) ? PROD_WIDTH + 1 : DOUT_WIDTH;
    localparam int EXT_W  = BASE_W + 1;
    localparam logic [EXT_W-1:0] RND = EXT_W'(round_const(SHIFT));

`ifdef HLS_MUL_PIPE_SAT_EN
    localparam logic [EXT_W-1:0] ONE = EXT_W'(1);
    localparam logic signed [EXT_W-1:0] S_MAX = $signed((ONE << (DOUT_WIDTH - 1)) - ONE);
    localparam logic signed [EXT_W-1:0] S_MIN = -$signed(ONE << (DOUT_WIDTH - 1));
    localparam logic signed [EXT_W-1:0] U_MAX = $signed((ONE << DOUT_WIDTH) - ONE);
`endif

    logic signed [EXT_W-1:0] prod_ext;
    logic signed [EXT_W-1:0] rounded;
    logic signed [EXT_W-1:0] shifted;

    always_comb begin
        prod_ext = SIGNED_OUT ? EXT_W'($signed(prod)) : EXT_W'(prod);
        rounded  = prod_ext + RND;
        shifted  = rounded >>> SHIFT;
`ifdef HLS_MUL_PIPE_SAT_EN
        if (shifted > (SIGNED_OUT ? S_MAX : U_MAX)) begin
            result = SIGNED_OUT ? DOUT_WIDTH'(S_MAX) : DOUT_WIDTH'(U_MAX);
        end else if (SIGNED_OUT && (shifted < S_MIN)) begin
            result = DOUT_WIDTH'(S_MIN);
        end else begin
            result = DOUT_WIDTH'(shifted);
        end
`else
        result = DOUT_WIDTH'(shifted);
`endif
    end

endmodule

// File: rtl/hls_mul_pipe.sv
// Fixed-latency pipelined multiplier with valid tracking and an occupancy counter.
// Define HLS_MUL_PIPE_SAT_EN to saturate the narrowed result instead of wrapping.
module hls_mul_pipe
    import hls_mul_pkg::*;
#(
    parameter int DIN0_WIDTH  = 32,
    parameter int DIN1_WIDTH  = 31,
    parameter int DOUT_WIDTH  = 58,
    parameter int NUM_STAGE   = 5,
    parameter int DIN0_SIGNED = 1,
    parameter int DIN1_SIGNED = 0,
    parameter int SHIFT       = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ce,
    input  logic                            in_valid,
    input  logic [DIN0_WIDTH-1:0]           din0,
    input  logic [DIN1_WIDTH-1:0]           din1,
    output logic [DOUT_WIDTH-1:0]           dout,
    output logic                            out_valid,
    output logic [clog2(NUM_STAGE+1)-1:0]   in_flight
);

    localparam int PROD_W = DIN0_WIDTH + DIN1_WIDTH;
    localparam int CNT_W  = clog2(NUM_STAGE + 1);
    localparam bit SIGNED_OUT = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

    generate
        if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX ||
            DIN0_WIDTH < 1 || DIN1_WIDTH < 1 || DOUT_WIDTH < 1 ||
            PROD_W > RND_MAX_W || SHIFT < 0 || SHIFT > PROD_W - 1 ||
            DIN0_SIGNED < 0 || DIN0_SIGNED > 1 ||
            DIN1_SIGNED < 0 || DIN1_SIGNED > 1) begin : g_param_check
            $error("hls_mul_pipe: illegal parameter combination");
        end
    endgenerate

    logic [DIN0_WIDTH-1:0] din0_q;
    logic [DIN1_WIDTH-1:0] din1_q;
    logic                  valid_q;
    logic [PROD_W-1:0]     op0_ext;
    logic [PROD_W-1:0]     op1_ext;
    logic [PROD_W-1:0]     prod;
    logic [PROD_W-1:0]     tail_prod;
    logic                  tail_valid;
    logic [DOUT_WIDTH-1:0] narrowed;

    always_ff @(posedge clk) begin
        if (!reset) begin
            din0_q  <= '0;
            din1_q  <= '0;
            valid_q <= 1'b0;
        end else if (ce) begin
            din0_q  <= din0;
            din1_q  <= din1;
            valid_q <= in_valid;
        end
    end

    // Operands widened to the full product width so the low bits are exact in either signedness.
    always_comb begin
        op0_ext = (DIN0_SIGNED != 0) ? PROD_W'($signed(din0_q)) : PROD_W'(din0_q);
        op1_ext = (DIN1_SIGNED != 0) ? PROD_W'($signed(din1_q)) : PROD_W'(din1_q);
        prod    = op0_ext * op1_ext;
    end

    generate
        if (NUM_STAGE > 2) begin : g_prod_pipe
            logic [PROD_W-1:0] prod_q  [NUM_STAGE-2];
            logic              valid_p [NUM_STAGE-2];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < NUM_STAGE - 2; i++) begin
                        prod_q[i]  <= '0;
                        valid_p[i] <= 1'b0;
                    end
                end else if (ce) begin
                    prod_q[0]  <= prod;
                    valid_p[0] <= valid_q;
                    for (int i = 1; i < NUM_STAGE - 2; i++) begin
                        prod_q[i]  <= prod_q[i-1];
                        valid_p[i] <= valid_p[i-1];
                    end
                end
            end

            assign tail_prod  = prod_q[NUM_STAGE-3];
            assign tail_valid = valid_p[NUM_STAGE-3];
        end else begin : g_no_prod_pipe
            assign tail_prod  = prod;
            assign tail_valid = valid_q;
        end
    endgenerate

    hls_mul_round_sat #(
        .PROD_WIDTH (PROD_W),
        .DOUT_WIDTH (DOUT_WIDTH),
        .SHIFT      (SHIFT),
        .SIGNED_OUT (SIGNED_OUT)
    ) u_round_sat (
        .prod   (tail_prod),
        .result (narrowed)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            dout      <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            dout      <= narrowed;
            out_valid <= tail_valid;
        end
    end

    // The output register counts as occupied; an item leaves when the next ce edge replaces it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_flight <= '0;
        end else if (ce) begin
            case ({in_valid, out_valid})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= in_flight - CNT_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

endmodule

// File: tb/tb_hls_mul_pipe.sv
// Directed bench for hls_mul_pipe: default, SHIFT=4 signed-din1 and 16-bit-output builds side by side.
module tb_hls_mul_pipe;

`ifdef HLS_MUL_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int NV = 11;

    typedef struct {
        logic [31:0] a;
        logic [30:0] b;
        longint      exp_a;
        longint      exp_b;
        logic [15:0] exp_c;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic [31:0] din0;
    logic [30:0] din1;
    logic [57:0] dout_a, dout_b;
    logic [15:0] dout_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [2:0]  in_flight_a, in_flight_b, in_flight_c;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    hls_mul_pipe u_dut_a (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .dout(dout_a), .out_valid(out_valid_a), .in_flight(in_flight_a)
    );

    hls_mul_pipe #(.SHIFT(4), .DIN1_SIGNED(1)) u_dut_b (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .dout(dout_b), .out_valid(out_valid_b), .in_flight(in_flight_b)
    );

    hls_mul_pipe #(.DOUT_WIDTH(16)) u_dut_c (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .dout(dout_c), .out_valid(out_valid_c), .in_flight(in_flight_c)
    );

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [30:0] b);
        in_valid = v;
        din0     = a;
        din1     = b;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [57:0] exp58;
        int idx;
        int entered;
        int left;

        vecs[0]  = '{32'hFFFF_FFFD, 31'd5,          -64'sd15,         -64'sd1,         16'hFFF1};
        vecs[1]  = '{32'd7,         31'd3,           64'sd21,          64'sd1,         16'd21};
        vecs[2]  = '{32'd8,         31'd3,           64'sd24,          64'sd2,         16'd24};
        vecs[3]  = '{32'hFFFF_FFFD, 31'd8,          -64'sd24,         -64'sd1,         16'hFFE8};
        vecs[4]  = '{32'h7FFF_FFFF, 31'd2,           64'sd4294967294,  64'sd268435456, SAT ? 16'h7FFF : 16'hFFFE};
        vecs[5]  = '{32'h8000_0000, 31'd1,          -64'sd2147483648, -64'sd134217728, SAT ? 16'h8000 : 16'h0000};
        vecs[6]  = '{32'hFFFF_FFFF, 31'h7FFF_FFFF,  -64'sd2147483647,  64'sd0,         SAT ? 16'h8000 : 16'h0001};
        vecs[7]  = '{32'd0,         31'd123,         64'sd0,           64'sd0,         16'h0000};
        vecs[8]  = '{32'h0000_7FFF, 31'd1,           64'sd32767,       64'sd2048,      16'h7FFF};
        vecs[9]  = '{32'hFFFF_8000, 31'd1,          -64'sd32768,      -64'sd2048,      16'h8000};
        vecs[10] = '{32'h0000_8000, 31'd1,           64'sd32768,       64'sd2048,      SAT ? 16'h7FFF : 16'h8000};

        reset = 1'b0;
        ce    = 1'b1;
        applyStimulus(1'b1, 32'd5, 31'd5);
        cycle();
        cycle();
        checkOutput("reset_dout_a",      dout_a,      0);
        checkOutput("reset_out_valid_a", out_valid_a, 0);
        checkOutput("reset_in_flight_a", in_flight_a, 0);
        checkOutput("reset_out_valid_b", out_valid_b, 0);
        checkOutput("reset_in_flight_c", in_flight_c, 0);
        applyStimulus(1'b0, 32'd0, 31'd0);
        reset = 1'b1;

        // Table vectors streamed back to back; row t emerges after edge t+5.
        for (int t = 0; t < NV + 5; t++) begin
            if (t < NV) applyStimulus(1'b1, vecs[t].a, vecs[t].b);
            else        applyStimulus(1'b0, 32'd0, 31'd0);
            cycle();
            idx = t - 4;
            if (idx >= 0 && idx < NV) begin
                checkOutput($sformatf("vec%0d_valid_a", idx), out_valid_a, 1);
                exp58 = vecs[idx].exp_a[57:0];
                checkOutput($sformatf("vec%0d_dout_a", idx), dout_a, exp58);
                exp58 = vecs[idx].exp_b[57:0];
                checkOutput($sformatf("vec%0d_dout_b", idx), dout_b, exp58);
                checkOutput($sformatf("vec%0d_valid_c", idx), out_valid_c, 1);
                checkOutput($sformatf("vec%0d_dout_c", idx), dout_c, vecs[idx].exp_c);
            end else if (idx >= NV) begin
                checkOutput("table_tail_valid_a", out_valid_a, 0);
                checkOutput("table_tail_in_flight_a", in_flight_a, 0);
            end
        end

        // Single item: out_valid pulses for exactly one cycle after the fifth edge.
        for (int k = 0; k < 6; k++) begin
            if (k == 0) applyStimulus(1'b1, 32'hFFFF_FFFD, 31'd5);
            else        applyStimulus(1'b0, 32'd0, 31'd0);
            cycle();
            checkOutput($sformatf("single_valid_k%0d", k), out_valid_a, (k == 4) ? 1 : 0);
            if (k == 4) checkOutput("single_dout", dout_a, 58'h3FF_FFFF_FFFF_FFF1);
        end

        // Eight back-to-back items 1..8 times 3.
        for (int t = 1; t <= 14; t++) begin
            applyStimulus((t <= 8), 32'(t), 31'd3);
            cycle();
            entered = (t < 8) ? t : 8;
            left    = (t > 5) ? ((t - 5 < 8) ? t - 5 : 8) : 0;
            checkOutput($sformatf("b2b_valid_t%0d", t), out_valid_a, (t >= 5 && t <= 12) ? 1 : 0);
            if (t >= 5 && t <= 12) checkOutput($sformatf("b2b_dout_t%0d", t), dout_a, 64'(3 * (t - 4)));
            checkOutput($sformatf("b2b_in_flight_t%0d", t), in_flight_a, 64'(entered - left));
        end

        // Three-cycle ce stall while one item is in the pipe.
        applyStimulus(1'b1, 32'd4, 31'd6);
        cycle();
        applyStimulus(1'b0, 32'd0, 31'd0);
        cycle();
        cycle();
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checkOutput($sformatf("stall_valid_k%0d", k), out_valid_a, 0);
            checkOutput($sformatf("stall_in_flight_k%0d", k), in_flight_a, 1);
        end
        ce = 1'b1;
        cycle();
        checkOutput("stall_early_valid", out_valid_a, 0);
        cycle();
        checkOutput("stall_out_valid", out_valid_a, 1);
        checkOutput("stall_dout", dout_a, 24);
        cycle();
        checkOutput("stall_after_valid", out_valid_a, 0);
        checkOutput("stall_after_in_flight", in_flight_a, 0);

        // Reset mid-flight discards three queued items.
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 32'(k), 31'd7);
            cycle();
        end
        applyStimulus(1'b0, 32'd0, 31'd0);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        checkOutput("midreset_out_valid", out_valid_a, 0);
        checkOutput("midreset_dout", dout_a, 0);
        checkOutput("midreset_in_flight", in_flight_a, 0);
        for (int k = 0; k < 8; k++) begin
            cycle();
            checkOutput($sformatf("midreset_drain_k%0d", k), out_valid_a, 0);
        end
        applyStimulus(1'b1, 32'd2, 31'd5);
        for (int k = 0; k < 5; k++) begin
            cycle();
            applyStimulus(1'b0, 32'd0, 31'd0);
            checkOutput($sformatf("postreset_valid_k%0d", k), out_valid_a, (k == 4) ? 1 : 0);
        end
        checkOutput("postreset_dout", dout_a, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
